hdmi_video_timing_ctrl: RTL and testbench

//  Sequences the three per-channel TMDS encoders of the HDMI output path.

---
 rtl/hdmi_timing_pkg.sv | 26 ++
 rtl/video_timing_counter.sv | 62 ++++++
 rtl/hdmi_video_timing_ctrl.sv | 159 +++++++++++++++
 tb/tb_hdmi_video_timing_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_timing_pkg.sv
// Shared encodings and raster constants for the HDMI video timing path.
// Default timing is 640x480@60; totals are derived, never hand-entered.
package hdmi_timing_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SYNC_WAIT = 2'd1,
    ST_RUN       = 2'd2
  } state_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_CW       = 12;

  function automatic int raster_total(input int active, input int fp, input int sync,
                                      input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/video_timing_counter.sv
// Horizontal/vertical raster counters with active and sync-window decode.
// Decode is combinational from the counter registers.
module video_timing_counter
  import hdmi_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int CW       = DEF_CW
) (
  input  logic          i_clk,
  input  logic          i_clear,
  output logic [CW-1:0] o_h_cnt,
  output logic [CW-1:0] o_v_cnt,
  output logic          o_act,
  output logic          o_hs,
  output logic          o_vs
);

  localparam int H_TOTAL = raster_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = raster_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  // One extra bit so a sync window ending exactly at 2**CW still compares correctly.
  localparam logic [CW:0] H_ACT_END = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0] HS_BEG    = (CW+1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0] HS_END    = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0] V_ACT_END = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0] VS_BEG    = (CW+1)'(V_ACTIVE + V_FP);
  localparam logic [CW:0] VS_END    = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);

  logic [CW-1:0] r_h_cnt;
  logic [CW-1:0] r_v_cnt;
  logic [CW:0]   w_h_ext;
  logic [CW:0]   w_v_ext;

  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == H_LAST) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + CW'(1);
    end else begin
      r_h_cnt <= r_h_cnt + CW'(1);
    end
  end

  assign w_h_ext = {1'b0, r_h_cnt};
  assign w_v_ext = {1'b0, r_v_cnt};
  assign o_h_cnt = r_h_cnt;
  assign o_v_cnt = r_v_cnt;
  assign o_act   = (w_h_ext < H_ACT_END) && (w_v_ext < V_ACT_END);
  assign o_hs    = (w_h_ext >= HS_BEG) && (w_h_ext < HS_END);
  assign o_vs    = (w_v_ext >= VS_BEG) && (w_v_ext < VS_END);

endmodule

// File: rtl/hdmi_video_timing_ctrl.sv
// Raster sequencer feeding the three TMDS encoders: FSM, pixel handshake, output registers.
// Pixel stream: a beat transfers on a CK edge where PIX_VALID & PIX_READY are both high.
module hdmi_video_timing_ctrl
  import hdmi_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = DEF_CW
) (
  input  logic          CK,
  input  logic          RESET,
  input  logic          ENABLE,
  input  logic          PIX_VALID,
  input  logic          PIX_SOF,
  input  logic [23:0]   PIX_DATA,
  output logic          PIX_READY,
  output logic          DE,
  output logic          HSYNC,
  output logic          VSYNC,
  output logic [7:0]    R,
  output logic [7:0]    G,
  output logic [7:0]    B,
  output logic [CW-1:0] H_CNT,
  output logic [CW-1:0] V_CNT,
  output logic          FRAME_START,
  output logic          UNDERFLOW,
  output logic          SOF_ERR,
  output state_t        DBG_STATE
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_clear;
  logic          w_act;
  logic          w_hs;
  logic          w_vs;
  logic          w_origin;
  logic          w_sof_pix;
  logic          w_ready;
  logic          w_run;
  logic          w_sof_err;
  logic          w_fire;
  logic [CW-1:0] w_h_cnt;
  logic [CW-1:0] w_v_cnt;
  logic          r_de;
  logic          r_hs;
  logic          r_vs;
  logic [23:0]   r_rgb;
  logic          r_fs;
  logic          r_underflow;
  logic          r_sof_err;

  assign w_clear = RESET | ~ENABLE | (r_state == ST_IDLE);

  video_timing_counter #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .CW(CW)
  ) u_counter (
    .i_clk  (CK),
    .i_clear(w_clear),
    .o_h_cnt(w_h_cnt),
    .o_v_cnt(w_v_cnt),
    .o_act  (w_act),
    .o_hs   (w_hs),
    .o_vs   (w_vs)
  );

  assign w_origin  = (w_h_cnt == '0) && (w_v_cnt == '0);
  assign w_sof_pix = PIX_VALID & PIX_SOF;

  always_ff @(posedge CK) begin
    if (RESET) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // w_run marks slots that belong to an aligned frame, including the SOF slot that leaves SYNC_WAIT.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_run       = 1'b0;
    w_sof_err   = 1'b0;
    case (r_state)
      ST_IDLE: w_state_nxt = ST_SYNC_WAIT;
      ST_SYNC_WAIT: begin
        if (!w_sof_pix) begin
          w_ready = 1'b1;
        end else if (w_origin) begin
          w_ready     = 1'b1;
          w_run       = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_run   = 1'b1;
        w_ready = w_act;
        if (w_act && w_sof_pix && !w_origin) begin
          w_ready     = 1'b0;
          w_sof_err   = 1'b1;
          w_state_nxt = ST_SYNC_WAIT;
        end else if (w_act && PIX_VALID && !PIX_SOF && w_origin) begin
          w_sof_err = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (!ENABLE || RESET) begin
      w_state_nxt = ST_IDLE;
      w_ready     = 1'b0;
      w_run       = 1'b0;
      w_sof_err   = 1'b0;
    end
  end

  assign w_fire = PIX_VALID & w_ready;

  always_ff @(posedge CK) begin
    if (w_clear) begin
      r_de        <= 1'b0;
      r_hs        <= ~HS_POL;
      r_vs        <= ~VS_POL;
      r_rgb       <= '0;
      r_fs        <= 1'b0;
      r_underflow <= 1'b0;
      r_sof_err   <= 1'b0;
    end else begin
      r_de        <= w_run & w_act;
      r_hs        <= w_hs ? HS_POL : ~HS_POL;
      r_vs        <= w_vs ? VS_POL : ~VS_POL;
      r_rgb       <= (w_run & w_act & w_fire) ? PIX_DATA : '0;
      r_fs        <= w_run & w_act & w_origin;
      r_underflow <= r_underflow | (w_run & w_act & ~PIX_VALID);
      r_sof_err   <= r_sof_err | w_sof_err;
    end
  end

  assign PIX_READY   = w_ready;
  assign DE          = r_de;
  assign HSYNC       = r_hs;
  assign VSYNC       = r_vs;
  assign R           = r_rgb[23:16];
  assign G           = r_rgb[15:8];
  assign B           = r_rgb[7:0];
  assign H_CNT       = w_h_cnt;
  assign V_CNT       = w_v_cnt;
  assign FRAME_START = r_fs;
  assign UNDERFLOW   = r_underflow;
  assign SOF_ERR     = r_sof_err;
  assign DBG_STATE   = r_state;

endmodule

// File: tb/tb_hdmi_video_timing_ctrl.sv
// Bench for hdmi_video_timing_ctrl on an 8x5 raster (H 4/1/2/1, V 2/1/1/1).
// Driver pushes expected pixels; a negedge monitor pops one per DE slot.
module tb_hdmi_video_timing_ctrl;
  import hdmi_timing_pkg::*;

  localparam int CW = 4;

  logic          ck = 1'b0;
  logic          reset;
  logic          enable;
  logic          pix_valid;
  logic          pix_sof;
  logic [23:0]   pix_data;
  logic          pix_ready;
  logic          de;
  logic          hsync;
  logic          vsync;
  logic [7:0]    r;
  logic [7:0]    g;
  logic [7:0]    b;
  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  logic          frame_start;
  logic          underflow;
  logic          sof_err;
  state_t        dbg_state;

  int checks = 0;
  int errors = 0;
  int fs_count = 0;
  int de_count = 0;
  logic [23:0] exp_q[$];
  bit mon_on = 1'b0;
  logic [CW-1:0] prev_h = '0;
  logic [CW-1:0] prev_v = '0;
  logic en_ok = 1'b0;
  logic m_exp_hs;
  logic m_exp_vs;
  logic m_exp_fs;
  logic [23:0] m_exp_pix;

  // clock / reset
  always #5 ck = ~ck;

  hdmi_video_timing_ctrl #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .CW(CW)
  ) dut (
    .CK(ck), .RESET(reset), .ENABLE(enable),
    .PIX_VALID(pix_valid), .PIX_SOF(pix_sof), .PIX_DATA(pix_data),
    .PIX_READY(pix_ready), .DE(de), .HSYNC(hsync), .VSYNC(vsync),
    .R(r), .G(g), .B(b), .H_CNT(h_cnt), .V_CNT(v_cnt),
    .FRAME_START(frame_start), .UNDERFLOW(underflow), .SOF_ERR(sof_err),
    .DBG_STATE(dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // driver tasks
  task automatic send(input logic sof, input logic [23:0] d);
    int n;
    logic rdy;
    n = 0;
    @(negedge ck);
    pix_valid = 1'b1;
    pix_sof   = sof;
    pix_data  = d;
    while (1) begin
      #1;
      rdy = pix_ready;
      @(posedge ck);
      if (rdy) break;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout actual=no_ready required=ready data=%0h", d);
        break;
      end
      @(negedge ck);
    end
  endtask

  task automatic send_exp(input logic sof, input logic [23:0] d);
    exp_q.push_back(d);
    send(sof, d);
  endtask

  task automatic gap();
    @(negedge ck);
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    exp_q.push_back(24'h0);
    @(posedge ck);
  endtask

  task automatic stop_and_wait(input int n);
    @(negedge ck);
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    repeat (n) @(negedge ck);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_de"}, de, 1'b0);
    check({tag, "_h_cnt"}, h_cnt, '0);
    check({tag, "_v_cnt"}, v_cnt, '0);
    check({tag, "_hsync"}, hsync, 1'b1);
    check({tag, "_vsync"}, vsync, 1'b1);
    check({tag, "_rgb"}, {r, g, b}, 24'h0);
    check({tag, "_ready"}, pix_ready, 1'b0);
    check({tag, "_frame_start"}, frame_start, 1'b0);
    check({tag, "_underflow"}, underflow, 1'b0);
    check({tag, "_sof_err"}, sof_err, 1'b0);
    check({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  // scoreboard / monitor
  always @(posedge ck) en_ok <= !reset && enable;

  initial begin
    forever begin
      @(negedge ck);
      if (mon_on) begin
        m_exp_hs = !(en_ok && prev_h >= 4'd5 && prev_h <= 4'd6);
        m_exp_vs = !(en_ok && prev_v == 4'd3);
        check("hsync", hsync, m_exp_hs);
        check("vsync", vsync, m_exp_vs);
        if (de) begin
          de_count++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL de_unexpected actual=%0h required=no_de", {r, g, b});
          end else begin
            m_exp_pix = exp_q.pop_front();
            check("pixel", {r, g, b}, m_exp_pix);
          end
        end else begin
          check("blank_rgb", {r, g, b}, 24'h0);
        end
        m_exp_fs = de && prev_h == '0 && prev_v == '0;
        check("frame_start", frame_start, m_exp_fs);
        if (frame_start) fs_count++;
      end
      prev_h = h_cnt;
      prev_v = v_cnt;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // stimulus
  initial begin
    reset = 1'b1; enable = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0; pix_data = '0;
    repeat (3) @(posedge ck);
    @(negedge ck);
    reset  = 1'b0;
    mon_on = 1'b1;
    repeat (10) @(negedge ck);
    check_reset_values("idle");

    // three pre-frame pixels are discarded, then two aligned frames
    enable = 1'b1;
    for (int i = 0; i < 3; i++) send(1'b0, 24'hEE0000 + 24'(i));
    for (int i = 0; i < 8; i++) send_exp(i == 0, 24'hA00000 + 24'(i * 24'h010101));
    for (int i = 0; i < 8; i++) send_exp(i == 0, 24'hB00000 + 24'(i * 24'h000301));
    stop_and_wait(3);
    check("f2_underflow", underflow, 1'b0);
    check("f2_sof_err", sof_err, 1'b0);
    check("f2_fs_count", fs_count, 2);
    check("f2_de_count", de_count, 16);
    check("f2_queue", exp_q.size(), 0);
    check("f2_state", dbg_state, ST_RUN);

    // missing pixel at slot (2,1)
    for (int i = 0; i < 6; i++) send_exp(i == 0, 24'hC00000 + 24'(i + 1));
    gap();
    send_exp(1'b0, 24'hC00007);
    stop_and_wait(3);
    check("f3_underflow", underflow, 1'b1);
    check("f3_sof_err", sof_err, 1'b0);

    // SOF at (1,0): error slot shows black, pixel realigns at next (0,0)
    send_exp(1'b1, 24'hD00000);
    exp_q.push_back(24'h0);
    send_exp(1'b1, 24'hE00000);
    for (int i = 1; i < 8; i++) send_exp(1'b0, 24'hE00000 + 24'(i * 24'h001100));
    stop_and_wait(3);
    check("f5_sof_err", sof_err, 1'b1);
    check("f5_underflow_sticky", underflow, 1'b1);
    check("f5_fs_count", fs_count, 5);
    check("f5_queue", exp_q.size(), 0);

    // reset mid active line
    send_exp(1'b1, 24'h0F0001);
    send_exp(1'b0, 24'h0F0002);
    @(negedge ck);
    check("pre_reset_underflow", underflow, 1'b1);
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    reset     = 1'b1;
    @(posedge ck);
    #1;
    check_reset_values("mid_reset");
    @(negedge ck);
    reset = 1'b0;

    // realign, then drop ENABLE mid active line
    for (int i = 0; i < 8; i++) send_exp(i == 0, 24'h123400 + 24'(i));
    send_exp(1'b1, 24'h5A5A5A);
    gap();
    @(negedge ck);
    check("pre_disable_underflow", underflow, 1'b1);
    enable = 1'b0;
    @(posedge ck);
    #1;
    check_reset_values("disable");
    repeat (4) @(negedge ck);
    check("end_fs_count", fs_count, 8);
    check("end_de_count", de_count, 46);
    check("end_queue", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
